// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with NREAD combinational read ports and one writeback port.
// A per-register pending-write counter flags RAW hazards. Writeback data can be forwarded.

// One architectural register: its data word plus its pending-writer counter.
module regfile_entry #(
  parameter int WORD     = 32,
  parameter int REG_SIZE = 5,
  parameter int CNT_W    = 2,
  parameter int IDX      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [REG_SIZE-1:0] wb_addr,
  input  logic [WORD-1:0]     wb_data,
  input  logic                issue_valid,
  input  logic [REG_SIZE-1:0] issue_rd,
  input  logic                flush,
  output logic [WORD-1:0]     data,
  output logic [CNT_W-1:0]    cnt,
  output logic                dec,
  output logic                full
);
  logic hit_wb, hit_is, inc;

  assign hit_wb = wb_valid && (wb_addr == REG_SIZE'(IDX));
  assign hit_is = issue_valid && (issue_rd == REG_SIZE'(IDX));
  assign dec    = hit_wb && (cnt != '0);
  // A retiring writer in the same cycle frees a slot, so a saturated counter can still accept.
  assign full   = (&cnt) && !dec;
  assign inc    = hit_is && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       data <= '0;
    else if (hit_wb) data <= wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (flush)        cnt <= '0;
    else if (inc && !dec)  cnt <= cnt + CNT_W'(1);
    else if (dec && !inc)  cnt <= cnt - CNT_W'(1);
  end
endmodule

// One read port: forwarding mux and hazard qualification.
module regfile_rdport #(
  parameter int WORD   = 32,
  parameter int BYPASS = 1
) (
  input  logic            ren,
  input  logic [WORD-1:0] rword,
  input  logic            rbusy,
  input  logic            rlast,
  input  logic            wb_hit,
  input  logic [WORD-1:0] wb_data,
  output logic [WORD-1:0] rdata,
  output logic            hazard
);
  localparam bit BYP = (BYPASS != 0);

  logic fwd, pending;

  assign fwd     = BYP && wb_hit;
  assign rdata   = fwd ? wb_data : rword;
  // The last outstanding writer retiring now resolves the hazard, because its data is forwarded.
  assign pending = rbusy && !(BYP && rlast);
  assign hazard  = ren && pending;
endmodule

module regfile_scoreboard #(
  parameter int WORD      = 32,
  parameter int REG_SIZE  = 5,
  parameter int REG_COUNT = 32,
  parameter int NREAD     = 2,
  parameter int CNT_W     = 2,
  parameter int BYPASS    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*REG_SIZE-1:0] raddr,
  input  logic [NREAD-1:0]          ren,
  output logic [NREAD*WORD-1:0]     rdata,
  output logic [NREAD-1:0]          hazard,
  input  logic                      issue_valid,
  input  logic [REG_SIZE-1:0]       issue_rd,
  output logic                      issue_ready,
  input  logic                      wb_valid,
  input  logic [REG_SIZE-1:0]       wb_addr,
  input  logic [WORD-1:0]           wb_data,
  input  logic                      flush,
  output logic [REG_COUNT-1:0]      busy
);
  // Arrays span the full address space; x0 and out-of-range slots are constant zero,
  // which makes them read as 0, never busy, and always ready.
  localparam int NREG = 1 << REG_SIZE;
  localparam logic [REG_SIZE:0] RC = REG_COUNT[REG_SIZE:0];

  logic [NREG-1:0][WORD-1:0]  grf;
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            dec;
  logic [NREG-1:0]            full;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r != 0 && r < REG_COUNT) begin : g_live
      regfile_entry #(
        .WORD(WORD), .REG_SIZE(REG_SIZE), .CNT_W(CNT_W), .IDX(r)
      ) u_ent (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .flush      (flush),
        .data       (grf[r]),
        .cnt        (cnt[r]),
        .dec        (dec[r]),
        .full       (full[r])
      );
      assign busy[r] = |cnt[r];
    end else begin : g_dead
      assign grf[r]  = '0;
      assign cnt[r]  = '0;
      assign dec[r]  = 1'b0;
      assign full[r] = 1'b0;
      if (r < REG_COUNT) begin : g_x0
        assign busy[r] = 1'b0;
      end
    end
  end

  assign issue_ready = !full[issue_rd];

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [REG_SIZE-1:0] ra;
    logic                wb_hit;

    assign ra     = raddr[i*REG_SIZE +: REG_SIZE];
    assign wb_hit = wb_valid && (wb_addr == ra) && (ra != '0) && ({1'b0, ra} < RC);

    regfile_rdport #(.WORD(WORD), .BYPASS(BYPASS)) u_rd (
      .ren    (ren[i]),
      .rword  (grf[ra]),
      .rbusy  (|cnt[ra]),
      .rlast  (dec[ra] && (cnt[ra] == CNT_W'(1))),
      .wb_hit (wb_hit),
      .wb_data(wb_data),
      .rdata  (rdata[i*WORD +: WORD]),
      .hazard (hazard[i])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, no-bypass and 3-port/24-register instances.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, wb_valid, flush;
  logic [4:0]  issue_rd, wb_addr;
  logic [31:0] wb_data;
  logic [9:0]  raddr;
  logic [1:0]  ren;
  logic [14:0] raddr3;
  logic [2:0]  ren3;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  hz_b, hz_n;
  logic        rdy_b, rdy_n, rdy3;
  logic [31:0] busy_b, busy_n;
  logic [95:0] rdata3;
  logic [2:0]  hz3;
  logic [23:0] busy3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .raddr(raddr), .ren(ren), .rdata(rdata_b), .hazard(hz_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rdy_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy(busy_b));

  regfile_scoreboard #(.BYPASS(0)) u_n (
    .clk(clk), .reset(reset), .raddr(raddr), .ren(ren), .rdata(rdata_n), .hazard(hz_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rdy_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy(busy_n));

  regfile_scoreboard #(.NREAD(3), .REG_COUNT(24), .BYPASS(1)) u_3 (
    .clk(clk), .reset(reset), .raddr(raddr3), .ren(ren3), .rdata(rdata3), .hazard(hz3),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(rdy3),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy(busy3));

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        wv;  logic [4:0] wa;  logic [31:0] wd;
    logic        fl;  logic [4:0] ra0; logic [4:0] ra1; logic [1:0] ren;
    logic [31:0] e0;  logic [31:0] e1; logic [1:0] ehz; logic erdy; logic [31:0] ebusy;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic wv, logic [4:0] wa,
                              logic [31:0] wd, logic fl, logic [4:0] ra0, logic [4:0] ra1,
                              logic [1:0] rn, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] ehz, logic erdy, logic [31:0] ebusy);
    vec_t v;
    v.iv = iv; v.ird = ird; v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl;
    v.ra0 = ra0; v.ra1 = ra1; v.ren = rn;
    v.e0 = e0; v.e1 = e1; v.ehz = ehz; v.erdy = erdy; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0;
    raddr = 0; ren = 0; raddr3 = 0; ren3 = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    clr();
    reset = 1;
    #2;
    chk("rst_rdata", {32'h0, rdata_b}, 96'h0);
    chk("rst_hazard", {94'h0, hz_b}, 96'h0);
    chk("rst_busy", {64'h0, busy_b}, 96'h0);
    chk("rst_ready", {95'h0, rdy_b}, 96'h1);
    #10 reset = 0;
    @(posedge clk); #1;

    //          iv ird wv wa  wd            fl ra0 ra1 ren    e0            e1            ehz    rdy busy
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 2'b11, 32'h0,        32'h0,        2'b00, 1, 32'h0);
    tbl[1]  = mk(0, 0, 1, 1, 32'h11111111, 0, 1, 2, 2'b00, 32'h11111111, 32'h0,        2'b00, 1, 32'h0);
    tbl[2]  = mk(0, 0, 1, 2, 32'h22,       0, 1, 2, 2'b00, 32'h11111111, 32'h22,       2'b00, 1, 32'h0);
    tbl[3]  = mk(1, 1, 0, 0, 32'h0,        0, 1, 1, 2'b11, 32'h11111111, 32'h11111111, 2'b00, 1, 32'h0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 2, 2'b01, 32'h11111111, 32'h22,       2'b01, 1, 32'h2);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 1, 2'b10, 32'h11111111, 32'h11111111, 2'b10, 1, 32'h2);
    tbl[6]  = mk(0, 0, 1, 1, 32'hAAAA,     0, 1, 1, 2'b11, 32'hAAAA,     32'hAAAA,     2'b00, 1, 32'h2);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 2, 2'b11, 32'hAAAA,     32'h22,       2'b00, 1, 32'h0);
    tbl[8]  = mk(1, 0, 1, 0, 32'hFFFF,     0, 0, 0, 2'b11, 32'h0,        32'h0,        2'b00, 1, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 2'b11, 32'h0,        32'hAAAA,     2'b00, 1, 32'h0);
    tbl[10] = mk(1, 4, 0, 0, 32'h0,        0, 4, 4, 2'b11, 32'h0,        32'h0,        2'b00, 1, 32'h0);
    tbl[11] = mk(1, 9, 0, 0, 32'h0,        0, 4, 9, 2'b11, 32'h0,        32'h0,        2'b01, 1, 32'h10);
    tbl[12] = mk(1, 2, 0, 0, 32'h0,        1, 4, 9, 2'b11, 32'h0,        32'h0,        2'b11, 1, 32'h210);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 2, 9, 2'b11, 32'h22,       32'h0,        2'b00, 1, 32'h0);

    for (int k = 0; k < 14; k++) begin
      issue_valid = tbl[k].iv; issue_rd = tbl[k].ird;
      wb_valid = tbl[k].wv; wb_addr = tbl[k].wa; wb_data = tbl[k].wd; flush = tbl[k].fl;
      raddr = {tbl[k].ra1, tbl[k].ra0}; ren = tbl[k].ren;
      #1;
      chk($sformatf("v%0d_rdata0", k), {64'h0, rdata_b[31:0]}, {64'h0, tbl[k].e0});
      chk($sformatf("v%0d_rdata1", k), {64'h0, rdata_b[63:32]}, {64'h0, tbl[k].e1});
      chk($sformatf("v%0d_hazard", k), {94'h0, hz_b}, {94'h0, tbl[k].ehz});
      chk($sformatf("v%0d_ready", k), {95'h0, rdy_b}, {95'h0, tbl[k].erdy});
      chk($sformatf("v%0d_busy", k), {64'h0, busy_b}, {64'h0, tbl[k].ebusy});
      nxt();
    end

    // Writeback forwarding versus no forwarding on x3.
    wb(3, 32'h5555); nxt();
    issue(3); nxt();
    raddr = 10'd3; ren = 2'b01; #1;
    chk("byp_pre_hz_b", {95'h0, hz_b[0]}, 96'h1);
    chk("byp_pre_hz_n", {95'h0, hz_n[0]}, 96'h1);
    nxt();
    raddr = 10'd3; ren = 2'b01; wb(3, 32'h1234); #1;
    chk("byp_wb_rdata_b", {64'h0, rdata_b[31:0]}, 96'h1234);
    chk("byp_wb_hz_b", {95'h0, hz_b[0]}, 96'h0);
    chk("nob_wb_rdata_n", {64'h0, rdata_n[31:0]}, 96'h5555);
    chk("nob_wb_hz_n", {95'h0, hz_n[0]}, 96'h1);
    chk("byp_wb_busy3", {95'h0, busy_b[3]}, 96'h1);
    nxt();
    raddr = 10'd3; ren = 2'b01; #1;
    chk("byp_post_rdata_b", {64'h0, rdata_b[31:0]}, 96'h1234);
    chk("nob_post_rdata_n", {64'h0, rdata_n[31:0]}, 96'h1234);
    chk("nob_post_hz_n", {95'h0, hz_n[0]}, 96'h0);
    chk("byp_post_busy3", {95'h0, busy_b[3]}, 96'h0);
    nxt();

    // Counter saturation on x7.
    for (int k = 0; k < 3; k++) begin issue(7); nxt(); end
    issue_rd = 7; raddr = 10'd7; ren = 2'b01; #1;
    chk("sat_ready", {95'h0, rdy_b}, 96'h0);
    chk("sat_busy7", {95'h0, busy_b[7]}, 96'h1);
    nxt();
    issue(7); wb(7, 32'h70); raddr = 10'd7; ren = 2'b01; #1;
    chk("sat_iss_wb_ready", {95'h0, rdy_b}, 96'h1);
    chk("sat_iss_wb_hz", {95'h0, hz_b[0]}, 96'h1);
    nxt();
    issue_rd = 7; #1;
    chk("sat_hold_ready", {95'h0, rdy_b}, 96'h0);
    nxt();
    issue_rd = 7; wb(7, 32'h71); raddr = 10'd7; ren = 2'b01; #1;
    chk("sat_wb1_ready", {95'h0, rdy_b}, 96'h1);
    chk("sat_wb1_hz", {95'h0, hz_b[0]}, 96'h1);
    nxt();
    wb(7, 32'h72); raddr = 10'd7; ren = 2'b01; #1;
    chk("sat_wb2_hz", {95'h0, hz_b[0]}, 96'h1);
    nxt();
    wb(7, 32'h73); raddr = 10'd7; ren = 2'b01; #1;
    chk("sat_wb3_hz_b", {95'h0, hz_b[0]}, 96'h0);
    chk("sat_wb3_hz_n", {95'h0, hz_n[0]}, 96'h1);
    chk("sat_wb3_busy7", {95'h0, busy_b[7]}, 96'h1);
    nxt();
    wb(7, 32'h74); #1;
    chk("sat_drained_busy7", {95'h0, busy_b[7]}, 96'h0);
    nxt();
    issue_rd = 7; #1;
    chk("sat_stray_busy7", {95'h0, busy_b[7]}, 96'h0);
    chk("sat_stray_ready", {95'h0, rdy_b}, 96'h1);
    nxt();

    // Three ports, simultaneous issue and ignored writeback on x6.
    issue(6); wb(6, 32'h66); raddr3 = {5'd0, 5'd6, 5'd6}; ren3 = 3'b111; #1;
    chk("n3_hz", {93'h0, hz3}, 96'h0);
    chk("n3_rdata0", {64'h0, rdata3[31:0]}, 96'h66);
    chk("n3_rdata2", {64'h0, rdata3[95:64]}, 96'h0);
    chk("n3_busy_pre", {72'h0, busy3}, 96'h0);
    nxt();
    raddr3 = {5'd0, 5'd6, 5'd6}; ren3 = 3'b111; #1;
    chk("n3_busy_post", {72'h0, busy3}, 96'h40);
    chk("n3_hz_post", {93'h0, hz3}, 96'h3);
    chk("n3_rdata0_post", {64'h0, rdata3[31:0]}, 96'h66);
    nxt();

    // Out-of-range register on the 24-register instance.
    issue(30); wb(30, 32'h77); raddr3 = {5'd0, 5'd30, 5'd30}; ren3 = 3'b111; #1;
    chk("oor_rdata0", {64'h0, rdata3[31:0]}, 96'h0);
    chk("oor_hz", {93'h0, hz3}, 96'h0);
    chk("oor_ready", {95'h0, rdy3}, 96'h1);
    nxt();
    raddr3 = {5'd0, 5'd30, 5'd30}; ren3 = 3'b111; #1;
    chk("oor_busy", {72'h0, busy3}, 96'h40);
    chk("oor_rdata0_post", {64'h0, rdata3[31:0]}, 96'h0);
    nxt();

    // Asynchronous reset between edges.
    wb(5, 32'hDEAD); nxt();
    issue(5); nxt();
    raddr = 10'd5; issue_rd = 5; #1;
    chk("mid_rdata_pre", {64'h0, rdata_b[31:0]}, 96'hDEAD);
    chk("mid_busy5_pre", {95'h0, busy_b[5]}, 96'h1);
    #1 reset = 1;
    #1;
    chk("mid_rdata_rst", {64'h0, rdata_b[31:0]}, 96'h0);
    chk("mid_busy_rst", {64'h0, busy_b}, 96'h0);
    chk("mid_ready_rst", {95'h0, rdy_b}, 96'h1);
    chk("mid_busy3_rst", {72'h0, busy3}, 96'h0);
    #1 reset = 0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
